if_unit: RTL and testbench

IF_UNIT -- requirements
Module: IF_unit

---
 rtl/if_unit_pkg.sv | 28 ++
 rtl/if_unit_pc_register.sv | 27 ++
 rtl/if_unit.sv | 86 ++++++++
 tb/tb_if_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/if_unit_pkg.sv
// Shared CPU definitions: opcodes, bubble word, fetch FSM encoding
// and the IF/ID bundle handed from fetch to decode.
package if_unit_pkg;

  localparam logic [3:0]  OP_HLT       = 4'hF;
  localparam logic [15:0] BUBBLE_INSTR = 16'h0000;
  localparam logic [15:0] RESET_PC     = 16'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        valid;
  } if_id_t;

  function automatic if_id_t bubble(input logic [15:0] word);
    if_id_t b;
    b.instr    = word;
    b.pc_plus2 = 16'h0000;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_unit_pc_register.sv
// Program counter storage: 16-bit register, sync active-low reset.
// Ports: clk, rst_n, we_i (load enable), d_i (load value), q_o (PC).
module if_unit_pc_register
  import if_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  logic [15:0] pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_VAL;
    end else if (we_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/if_unit.sv
// Instruction fetch stage: PC, IF/ID register and RUN/HALTED FSM.
// Ports: clk, rst_n, imemAddr/imemData (comb imem), stall_IF,
// branchTaken_ID/branchTarget_ID (redirect), currInstruction,
// pcPlus2_ID, instValid_ID (IF/ID outputs), HLT_IF (halted flag).
module if_unit
  import if_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = if_unit_pkg::RESET_PC,
  parameter logic [15:0] BUBBLE_INSTR = if_unit_pkg::BUBBLE_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imemAddr,
  input  logic [15:0] imemData,
  input  logic        stall_IF,
  input  logic        branchTaken_ID,
  input  logic [15:0] branchTarget_ID,
  output logic [15:0] currInstruction,
  output logic [15:0] pcPlus2_ID,
  output logic        instValid_ID,
  output logic        HLT_IF
);

  fetch_state_e state_q, state_d;
  if_id_t       ifid_q, ifid_d;
  logic [15:0]  pc_q, pc_d, pc_plus2;
  logic         pc_we;

  if_unit_pc_register #(
    .RESET_VAL(RESET_PC)
  ) u_pc_register (
    .clk  (clk),
    .rst_n(rst_n),
    .we_i (pc_we),
    .d_i  (pc_d),
    .q_o  (pc_q)
  );

  // Wraps modulo 2^16 by width truncation.
  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    state_d = state_q;
    ifid_d  = ifid_q;
    pc_we   = 1'b0;
    pc_d    = pc_q;
    if (branchTaken_ID) begin
      // Redirect wins over stall and over a HLT fetched this cycle.
      pc_we   = 1'b1;
      pc_d    = {branchTarget_ID[15:1], 1'b0};
      ifid_d  = bubble(BUBBLE_INSTR);
      state_d = RUN;
    end else if (stall_IF) begin
      state_d = state_q;
    end else if (state_q == RUN) begin
      ifid_d.instr    = imemData;
      ifid_d.pc_plus2 = pc_plus2;
      ifid_d.valid    = 1'b1;
      if (imemData[15:12] == OP_HLT) begin
        state_d = HALTED;
      end else begin
        pc_we = 1'b1;
        pc_d  = pc_plus2;
      end
    end else begin
      ifid_d = bubble(BUBBLE_INSTR);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      ifid_q  <= bubble(BUBBLE_INSTR);
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
    end
  end

  assign imemAddr        = pc_q;
  assign currInstruction = ifid_q.instr;
  assign pcPlus2_ID      = ifid_q.pc_plus2;
  assign instValid_ID    = ifid_q.valid;
  assign HLT_IF          = (state_q == HALTED);

endmodule

// File: tb/tb_if_unit.sv
// Directed testbench for if_unit with a combinational imem model.
// Checks reset, fetch, stall, redirect, halt, PC wrap.
module tb_if_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imemAddr;
  logic [15:0] imemData;
  logic        stall_IF;
  logic        branchTaken_ID;
  logic [15:0] branchTarget_ID;
  logic [15:0] currInstruction;
  logic [15:0] pcPlus2_ID;
  logic        instValid_ID;
  logic        HLT_IF;

  logic [15:0] mem [0:32767];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign imemData = mem[imemAddr[15:1]];

  if_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imemAddr       (imemAddr),
    .imemData       (imemData),
    .stall_IF       (stall_IF),
    .branchTaken_ID (branchTaken_ID),
    .branchTarget_ID(branchTarget_ID),
    .currInstruction(currInstruction),
    .pcPlus2_ID     (pcPlus2_ID),
    .instValid_ID   (instValid_ID),
    .HLT_IF         (HLT_IF)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] ins,
                          input logic [15:0] p2, input logic v,
                          input logic [15:0] addr, input logic h);
    chk({tag, ".instr"}, currInstruction, ins);
    chk({tag, ".pc2"},   pcPlus2_ID, p2);
    chk({tag, ".valid"}, {15'd0, instValid_ID}, {15'd0, v});
    chk({tag, ".addr"},  imemAddr, addr);
    chk({tag, ".hlt"},   {15'd0, HLT_IF}, {15'd0, h});
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h7000;
    mem[0]      = 16'h1123;
    mem[1]      = 16'h2456;
    mem[2]      = 16'h3789;
    mem[4]      = 16'hF000;
    mem[16'h20] = 16'h5A5A;
    mem[16'h7FFF] = 16'h6123;

    rst_n = 1'b0; stall_IF = 1'b1; branchTaken_ID = 1'b1;
    branchTarget_ID = 16'h1234;
    step(); step();
    chk_ifid("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    rst_n = 1'b1; stall_IF = 1'b0; branchTaken_ID = 1'b0;
    chk("release.addr", imemAddr, 16'h0000);
    step();
    chk_ifid("fetch0", 16'h1123, 16'h0002, 1'b1, 16'h0002, 1'b0);
    step();
    chk_ifid("fetch2", 16'h2456, 16'h0004, 1'b1, 16'h0004, 1'b0);

    stall_IF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid("stall", 16'h2456, 16'h0004, 1'b1, 16'h0004, 1'b0);
    end
    stall_IF = 1'b0;
    step();
    chk_ifid("resume", 16'h3789, 16'h0006, 1'b1, 16'h0006, 1'b0);

    branchTaken_ID = 1'b1; branchTarget_ID = 16'h0041; stall_IF = 1'b1;
    step();
    chk_ifid("br_stall", 16'h0000, 16'h0000, 1'b0, 16'h0040, 1'b0);
    branchTaken_ID = 1'b0; stall_IF = 1'b0;
    step();
    chk_ifid("br_tgt", 16'h5A5A, 16'h0042, 1'b1, 16'h0042, 1'b0);

    branchTaken_ID = 1'b1; branchTarget_ID = 16'h0008;
    step();
    chk_ifid("br8", 16'h0000, 16'h0000, 1'b0, 16'h0008, 1'b0);
    branchTarget_ID = 16'h0010;
    step();
    chk_ifid("hlt_vs_br", 16'h0000, 16'h0000, 1'b0, 16'h0010, 1'b0);
    branchTarget_ID = 16'h0008;
    step();
    branchTaken_ID = 1'b0;
    step();
    chk_ifid("hlt", 16'hF000, 16'h000A, 1'b1, 16'h0008, 1'b1);
    step();
    chk_ifid("halted1", 16'h0000, 16'h0000, 1'b0, 16'h0008, 1'b1);
    step();
    chk_ifid("halted2", 16'h0000, 16'h0000, 1'b0, 16'h0008, 1'b1);

    branchTaken_ID = 1'b1; branchTarget_ID = 16'hFFFF;
    step();
    chk_ifid("br_wrap", 16'h0000, 16'h0000, 1'b0, 16'hFFFE, 1'b0);
    branchTaken_ID = 1'b0;
    step();
    chk_ifid("wrap", 16'h6123, 16'h0000, 1'b1, 16'h0000, 1'b0);

    branchTaken_ID = 1'b1; branchTarget_ID = 16'h0008;
    step();
    branchTaken_ID = 1'b0;
    step(); step();
    chk("halt2.hlt", {15'd0, HLT_IF}, 16'h0001);
    stall_IF = 1'b1; rst_n = 1'b0;
    step();
    chk_ifid("rst_halt", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b1; stall_IF = 1'b0;
    chk("restart.addr", imemAddr, 16'h0000);
    step();
    chk_ifid("restart", 16'h1123, 16'h0002, 1'b1, 16'h0002, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
